mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
//  Parametrised successor of the single-port request unit. Arbitrates NCH level-held memory
//  requesters (ch0 = instruction fetch, higher = data ports) onto one cache/memory port.
//  Holds each granted op/address stable until mem_hit, with optional round-robin and timeout.
//  Handles halt by draining the in-flight op and then parking the port.
// PARAMETERS
//  NCH      2   number of requester channels (>=2)
//  ADDR_W   32  address width
//  RR_MODE  0   0 = fixed priority, highest index wins; 1 = round-robin
//  TIMEOUT  0   BUSY cycles before forced abort; 0 = disabled
// PORTS
//  CLK        in   1             clock, rising edge
//  RST        in   1             asynchronous active-high reset
//  req_ren    in   NCH           per-channel read request, level, held until ch_done
//  req_wen    in   NCH           per-channel write request, level, held until ch_done
//  req_addr   in   NCH*ADDR_W    per-channel address, ch i at [i*ADDR_W +: ADDR_W]
//  halt       in   1             halt request from datapath
//  mem_hit    in   1             port completion for the current op
//  mem_ren    out  1             port read enable
//  mem_wen    out  1             port write enable
//  mem_addr   out  ADDR_W        port address
//  grant_id   out  $clog2(NCH)   channel owning the current op
//  ch_done    out  NCH           one-hot completion pulse
//  busy       out  1             op outstanding
//  halt_out   out  1             port parked after halt
//  timeout_err out 1             sticky timeout flag
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rr_ptr = NCH-1, so ch0 wins the first RR arbitration.
//  States:
//   - IDLE: if any req and halt_reg = 0, arbitrate, latch {op, addr, id}, go to BUSY.
//   - BUSY: on mem_hit or timeout, pulse done. Go to HALTED if halt_reg, else BUSY with the
//     next grant if any req remains (no bubble), else IDLE.
//   - HALTED: sticky until RST; no grants.
//  Channel op: WEN has priority over REN on the same channel; the op is req_wen|req_ren.
//  Latency: req seen in cycle N -> mem_ren/mem_wen/mem_addr registered and valid in N+1.
//  Outputs in BUSY: mem_ren/mem_wen/mem_addr/grant_id come from registers and are stable
//   until the done cycle. mem_ren and mem_wen are never both 1 and are 0 outside BUSY.
//  ch_done[g]: combinational = BUSY & (mem_hit | tmo) & grant_id==g.
//   - The granting channel is excluded from arbitration in its done cycle.
//   - Its req in the following cycle is treated as a new request.
//  Dropping req while BUSY does not abort; the op still completes and ch_done still pulses.
//  Arbitration:
//   - Fixed priority: the highest requesting index wins.
//   - RR: search from rr_ptr+1 upward with wrap mod NCH; rr_ptr <= granted id.
//  halt:
//   - Registered into halt_reg; new grants are blocked from the cycle after halt is seen.
//   - The in-flight op completes normally; then go to HALTED.
//   - halt_out = (state==HALTED); busy = (state==BUSY).
//  Timeout (TIMEOUT>0): a counter resets on each grant and increments each BUSY cycle.
//   - At count TIMEOUT-1 without mem_hit: tmo, abort, ch_done pulses, timeout_err <= 1.
//   - timeout_err stays set until RST. mem_hit in the same cycle counts as a hit, no error.
//  RST mid-op: immediate return to IDLE, outputs 0, no ch_done pulse.
// TESTING
//  1. Reset, req_ren[0]=1 addr 0x100 -> mem_ren=1, mem_addr=0x100 next cycle; hit 3 cyc
//     later -> ch_done=01; addr stable across the wait.
//  2. Fixed prio: req_ren[0] and req_wen[1] (0x200) same cycle -> ch1 write first, ch0 read
//     granted in the ch1 done cycle+1 with no idle cycle.
//  3. RR_MODE=1, NCH=3, all channels requesting continuously -> grants 0,1,2,0,...;
//     one grant per mem_hit.
//  4. halt asserted while BUSY with hit 2 cyc later -> op completes, ch_done pulses,
//     halt_out=1, later reqs never reach mem_ren/mem_wen.
//  5. TIMEOUT=4, never hit -> ch_done pulses in the 4th BUSY cycle, timeout_err=1 sticky;
//     hit arriving on the 4th cycle -> no error.
//  6. RST mid-BUSY -> all outputs 0 asynchronously; after release, still-held req is reissued.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// rtl/mem_request_arbiter_if.sv - requester/memory-port bundle for mem_request_arbiter
interface mem_request_arbiter_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32
);
    logic [NCH-1:0]          req_ren;
    logic [NCH-1:0]          req_wen;
    logic [NCH*ADDR_W-1:0]   req_addr;
    logic                    halt;
    logic                    mem_hit;
    logic                    mem_ren;
    logic                    mem_wen;
    logic [ADDR_W-1:0]       mem_addr;
    logic [$clog2(NCH)-1:0]  grant_id;
    logic [NCH-1:0]          ch_done;
    logic                    busy;
    logic                    halt_out;
    logic                    timeout_err;

    // master = the arbiter, which owns the memory port
    modport master (
        input  req_ren, req_wen, req_addr, halt, mem_hit,
        output mem_ren, mem_wen, mem_addr, grant_id, ch_done, busy, halt_out, timeout_err
    );

    modport slave (
        output req_ren, req_wen, req_addr, halt, mem_hit,
        input  mem_ren, mem_wen, mem_addr, grant_id, ch_done, busy, halt_out, timeout_err
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - NCH-channel memory request arbiter with halt drain and timeout
module mem_request_arbiter #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 32,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_request_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NCH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] HALTED = 2'b10;

    logic [1:0]        state;
    logic              halt_reg;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gid;
    logic [CNT_W-1:0]  cnt;
    logic              mem_ren_r;
    logic              mem_wen_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              timeout_err_r;

    logic              tmo;
    logic              done;
    logic [NCH-1:0]    done_vec;
    logic [NCH-1:0]    req_vec;
    logic              any_req;
    logic              found;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   idx;
    int                s;
    logic              grant_now;
    logic [ADDR_W-1:0] pick_addr;

    generate
        if (TIMEOUT > 0) begin : g_tmo
            assign tmo = (state == BUSY) && (cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign tmo = 1'b0;
        end
    endgenerate

    assign done = (state == BUSY) && (bus.mem_hit || tmo);

    always_comb begin
        done_vec = '0;
        if (done) done_vec[gid] = 1'b1;
    end

    // the finishing channel sits out this cycle's arbitration; a held req counts as new next cycle
    assign req_vec = (bus.req_ren | bus.req_wen) & ~done_vec;
    assign any_req = |req_vec;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        s     = 0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NCH; i++) begin
                idx = ID_W'(i);
                if (req_vec[idx]) pick = idx;
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                s = int'(rr_ptr) + k;
                if (s >= NCH) s = s - NCH;
                idx = ID_W'(s);
                if (!found && req_vec[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign pick_addr = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
    assign grant_now = !halt_reg && any_req && ((state == IDLE) || done);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            halt_reg      <= 1'b0;
            rr_ptr        <= ID_W'(NCH - 1);
            gid           <= '0;
            cnt           <= '0;
            mem_ren_r     <= 1'b0;
            mem_wen_r     <= 1'b0;
            mem_addr_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            halt_reg <= halt_reg | bus.halt;
            if (tmo && !bus.mem_hit) timeout_err_r <= 1'b1;
            if (state != HALTED) begin
                if (grant_now) begin
                    state      <= BUSY;
                    gid        <= pick;
                    mem_wen_r  <= bus.req_wen[pick];
                    mem_ren_r  <= bus.req_ren[pick] & ~bus.req_wen[pick];
                    mem_addr_r <= pick_addr;
                    cnt        <= '0;
                    if (RR_MODE != 0) rr_ptr <= pick;
                end else if ((state != BUSY) || done) begin
                    // halt_reg parks the port once nothing is in flight
                    state      <= halt_reg ? HALTED : IDLE;
                    mem_ren_r  <= 1'b0;
                    mem_wen_r  <= 1'b0;
                    mem_addr_r <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.mem_ren     = mem_ren_r;
    assign bus.mem_wen     = mem_wen_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.grant_id    = gid;
    assign bus.ch_done     = done_vec;
    assign bus.busy        = (state == BUSY);
    assign bus.halt_out    = (state == HALTED);
    assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - self-checking bench for mem_request_arbiter
module tb_mem_request_arbiter;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [2:0]  req_ren, req_wen;
    logic [95:0] req_addr;
    logic        halt, mem_hit;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // instance 0: fixed priority, 1: round-robin, 2: fixed priority with TIMEOUT=4
    mem_request_arbiter_if #(.NCH(3), .ADDR_W(32)) ifa ();
    mem_request_arbiter_if #(.NCH(3), .ADDR_W(32)) ifb ();
    mem_request_arbiter_if #(.NCH(3), .ADDR_W(32)) ifc ();

    assign ifa.req_ren = req_ren;  assign ifb.req_ren = req_ren;  assign ifc.req_ren = req_ren;
    assign ifa.req_wen = req_wen;  assign ifb.req_wen = req_wen;  assign ifc.req_wen = req_wen;
    assign ifa.req_addr = req_addr; assign ifb.req_addr = req_addr; assign ifc.req_addr = req_addr;
    assign ifa.halt = halt;        assign ifb.halt = halt;        assign ifc.halt = halt;
    assign ifa.mem_hit = mem_hit;  assign ifb.mem_hit = mem_hit;  assign ifc.mem_hit = mem_hit;

    mem_request_arbiter #(.NCH(3), .ADDR_W(32), .RR_MODE(0), .TIMEOUT(0)) u_fix (.CLK(CLK), .RST(RST), .bus(ifa));
    mem_request_arbiter #(.NCH(3), .ADDR_W(32), .RR_MODE(1), .TIMEOUT(0)) u_rr  (.CLK(CLK), .RST(RST), .bus(ifb));
    mem_request_arbiter #(.NCH(3), .ADDR_W(32), .RR_MODE(0), .TIMEOUT(4)) u_tmo (.CLK(CLK), .RST(RST), .bus(ifc));

    logic        o_ren[3], o_wen[3], o_busy[3], o_hout[3], o_err[3];
    logic [31:0] o_addr[3];
    logic [1:0]  o_gid[3];
    logic [2:0]  o_done[3];

    assign o_ren[0] = ifa.mem_ren;      assign o_ren[1] = ifb.mem_ren;      assign o_ren[2] = ifc.mem_ren;
    assign o_wen[0] = ifa.mem_wen;      assign o_wen[1] = ifb.mem_wen;      assign o_wen[2] = ifc.mem_wen;
    assign o_busy[0] = ifa.busy;        assign o_busy[1] = ifb.busy;        assign o_busy[2] = ifc.busy;
    assign o_hout[0] = ifa.halt_out;    assign o_hout[1] = ifb.halt_out;    assign o_hout[2] = ifc.halt_out;
    assign o_err[0] = ifa.timeout_err;  assign o_err[1] = ifb.timeout_err;  assign o_err[2] = ifc.timeout_err;
    assign o_addr[0] = ifa.mem_addr;    assign o_addr[1] = ifb.mem_addr;    assign o_addr[2] = ifc.mem_addr;
    assign o_gid[0] = ifa.grant_id;     assign o_gid[1] = ifb.grant_id;     assign o_gid[2] = ifc.grant_id;
    assign o_done[0] = ifa.ch_done;     assign o_done[1] = ifb.ch_done;     assign o_done[2] = ifc.ch_done;

    // transaction-level reference: who owns the port, what op, how long, halted or not
    int          P_RR[3]  = '{0, 1, 0};
    int          P_TMO[3] = '{0, 0, 4};
    int          m_owner[3], m_age[3], m_ptr[3];
    bit          m_w[3], m_hreg[3], m_halted[3], m_err[3];
    logic [31:0] m_addr[3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1; m_age[k] = 0; m_ptr[k] = 2; m_w[k] = 0;
            m_hreg[k] = 0; m_halted[k] = 0; m_err[k] = 0; m_addr[k] = 0;
        end
    endtask

    task automatic model_step();
        bit expired, d;
        int pend, pick;
        for (int k = 0; k < 3; k++) begin
            expired = (m_owner[k] >= 0) && (P_TMO[k] > 0) && (m_age[k] == P_TMO[k] - 1);
            d = (m_owner[k] >= 0) && (mem_hit || expired);
            if (expired && !mem_hit) m_err[k] = 1;
            pend = int'(req_ren | req_wen);
            if (d) pend = pend & ~(1 << m_owner[k]);
            if (!m_halted[k]) begin
                if (m_owner[k] < 0 || d) begin
                    if (m_hreg[k]) begin
                        m_halted[k] = 1; m_owner[k] = -1;
                    end else if (pend != 0) begin
                        pick = -1;
                        if (P_RR[k] == 0) begin
                            for (int c = 0; c < 3; c++) if (pend[c]) pick = c;
                        end else begin
                            for (int j = 1; j <= 3; j++) begin
                                int c;
                                c = (m_ptr[k] + j) % 3;
                                if (pick < 0 && pend[c]) pick = c;
                            end
                            m_ptr[k] = pick;
                        end
                        m_owner[k] = pick;
                        m_w[k]     = req_wen[pick];
                        m_addr[k]  = req_addr[pick*32 +: 32];
                        m_age[k]   = 0;
                    end else begin
                        m_owner[k] = -1;
                    end
                end else begin
                    m_age[k]++;
                end
            end
            m_hreg[k] = m_hreg[k] | halt;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) model_reset(); else model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        req_ren = 0; req_wen = 0; req_addr = 0; halt = 0; mem_hit = 0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({o_ren[k], o_wen[k], o_busy[k], o_hout[k], o_err[k], o_done[k], o_addr[k], o_gid[k]} !== 40'd0)
                $display("FAIL reset k=%0d got ren%0b wen%0b busy%0b hout%0b err%0b done%0b addr%0h gid%0d exp all 0",
                         k, o_ren[k], o_wen[k], o_busy[k], o_hout[k], o_err[k], o_done[k], o_addr[k], o_gid[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        do_reset();
        req_ren = 3'b001; req_addr[31:0] = 32'h100;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin mem_hit = 1; req_ren = 0; end
            #1;
            for (int k = 0; k < 3; k++) begin
                total_cnt++;
                if ({o_ren[k], o_wen[k], o_busy[k], o_addr[k], o_gid[k], o_done[k]} !==
                    {1'b1, 1'b0, 1'b1, 32'h100, 2'd0, (c == 2) ? 3'b001 : 3'b000})
                    $display("FAIL single k=%0d cyc=%0d got ren%0b addr%0h done%0b exp ren1 addr100 done%0b",
                             k, c, o_ren[k], o_addr[k], o_done[k], (c == 2) ? 3'b001 : 3'b000);
                else pass_cnt++;
            end
            tick();
        end
        mem_hit = 0; #1;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({o_busy[k], o_ren[k]} !== 2'b00)
                $display("FAIL single_idle k=%0d got busy%0b ren%0b exp 00", k, o_busy[k], o_ren[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req_ren = 3'b001; req_wen = 3'b010;
        req_addr[31:0] = 32'h100; req_addr[63:32] = 32'h200;
        tick(); #1;
        total_cnt++;
        if ({o_wen[0], o_ren[0], o_gid[0], o_addr[0]} !== {1'b1, 1'b0, 2'd1, 32'h200})
            $display("FAIL prio_first got wen%0b ren%0b gid%0d addr%0h exp wen1 ren0 gid1 addr200",
                     o_wen[0], o_ren[0], o_gid[0], o_addr[0]);
        else pass_cnt++;
        mem_hit = 1; req_wen = 0; #1;
        total_cnt++;
        if (o_done[0] !== 3'b010) $display("FAIL prio_done got %0b exp 010", o_done[0]);
        else pass_cnt++;
        tick(); mem_hit = 0; #1;
        total_cnt++;
        if ({o_busy[0], o_ren[0], o_wen[0], o_gid[0], o_addr[0]} !== {1'b1, 1'b1, 1'b0, 2'd0, 32'h100})
            $display("FAIL prio_second got busy%0b ren%0b wen%0b gid%0d addr%0h exp busy1 ren1 wen0 gid0 addr100",
                     o_busy[0], o_ren[0], o_wen[0], o_gid[0], o_addr[0]);
        else pass_cnt++;
    endtask

    task automatic test_rr();
        do_reset();
        req_ren = 3'b111;
        req_addr = {32'h3000, 32'h2000, 32'h1000};
        tick();
        for (int i = 0; i < 7; i++) begin
            #1;
            total_cnt++;
            if ({o_busy[1], o_gid[1], o_addr[1]} !== {1'b1, 2'(i % 3), 32'h1000 * (i % 3 + 1)})
                $display("FAIL rr_grant i=%0d got gid%0d addr%0h exp gid%0d", i, o_gid[1], o_addr[1], i % 3);
            else pass_cnt++;
            tick(); #1;
            total_cnt++;
            if ({o_gid[1], o_done[1]} !== {2'(i % 3), 3'b000})
                $display("FAIL rr_hold i=%0d got gid%0d done%0b exp gid%0d done0", i, o_gid[1], o_done[1], i % 3);
            else pass_cnt++;
            mem_hit = 1; #1;
            total_cnt++;
            if (o_done[1] !== 3'(1 << (i % 3)))
                $display("FAIL rr_done i=%0d got %0b exp %0b", i, o_done[1], 3'(1 << (i % 3)));
            else pass_cnt++;
            tick(); mem_hit = 0;
        end
    endtask

    task automatic test_halt();
        do_reset();
        req_ren = 3'b001; req_addr[31:0] = 32'h40;
        tick();
        req_wen = 3'b010; halt = 1;
        tick();
        halt = 0;
        tick();
        mem_hit = 1; req_ren = 0; #1;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({o_done[k], o_ren[k], o_addr[k]} !== {3'b001, 1'b1, 32'h40})
                $display("FAIL halt_drain k=%0d got done%0b ren%0b addr%0h exp done001 ren1 addr40",
                         k, o_done[k], o_ren[k], o_addr[k]);
            else pass_cnt++;
        end
        tick(); mem_hit = 0;
        for (int c = 0; c < 5; c++) begin
            req_ren = 3'($urandom_range(1, 7)); req_wen = 3'($urandom_range(1, 7));
            #1;
            for (int k = 0; k < 3; k++) begin
                total_cnt++;
                if ({o_hout[k], o_busy[k], o_ren[k], o_wen[k]} !== 4'b1000)
                    $display("FAIL halt_park k=%0d cyc=%0d got hout%0b busy%0b ren%0b wen%0b exp 1000",
                             k, c, o_hout[k], o_busy[k], o_ren[k], o_wen[k]);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            req_ren = 3'b001;
            tick();
            for (int c = 1; c <= 4; c++) begin
                if (c == 4) begin req_ren = 0; mem_hit = (pass == 1); end
                #1;
                total_cnt++;
                if (o_done[2] !== ((c == 4) ? 3'b001 : 3'b000))
                    $display("FAIL tmo_done pass=%0d cyc=%0d got %0b exp %0b",
                             pass, c, o_done[2], (c == 4) ? 3'b001 : 3'b000);
                else pass_cnt++;
                tick();
            end
            mem_hit = 0;
            for (int c = 0; c < 3; c++) begin
                #1;
                total_cnt++;
                if ({o_err[2], o_busy[2]} !== {(pass == 0), 1'b0})
                    $display("FAIL tmo_err pass=%0d cyc=%0d got err%0b busy%0b exp err%0b busy0",
                             pass, c, o_err[2], o_busy[2], pass == 0);
                else pass_cnt++;
                tick();
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        req_wen = 3'b100; req_addr[95:64] = 32'hABC;
        tick();
        #2 RST = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({o_busy[k], o_wen[k], o_ren[k], o_done[k], o_addr[k]} !== 38'd0)
                $display("FAIL rst_async k=%0d got busy%0b wen%0b done%0b addr%0h exp all 0",
                         k, o_busy[k], o_wen[k], o_done[k], o_addr[k]);
            else pass_cnt++;
        end
        @(negedge CLK);
        RST = 1'b0;
        tick(); #1;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({o_busy[k], o_wen[k], o_gid[k], o_addr[k]} !== {1'b1, 1'b1, 2'd2, 32'hABC})
                $display("FAIL rst_reissue k=%0d got busy%0b wen%0b gid%0d addr%0h exp busy1 wen1 gid2 addrABC",
                         k, o_busy[k], o_wen[k], o_gid[k], o_addr[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bit          e_busy, e_tmo;
        logic [2:0]  e_done;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_ren  = 3'($urandom);
            req_wen  = 3'($urandom & $urandom);
            req_addr = {$urandom, $urandom, $urandom};
            mem_hit  = ($urandom_range(0, 2) == 0);
            halt     = (i == 350);
            #1;
            for (int k = 0; k < 3; k++) begin
                e_busy = (m_owner[k] >= 0);
                e_tmo  = e_busy && (P_TMO[k] > 0) && (m_age[k] == P_TMO[k] - 1);
                e_done = (e_busy && (mem_hit || e_tmo)) ? 3'(1 << m_owner[k]) : 3'b000;
                total_cnt++;
                if ({o_ren[k], o_wen[k], o_busy[k], o_hout[k], o_err[k], o_done[k]} !==
                    {e_busy && !m_w[k], e_busy && m_w[k], e_busy, m_halted[k], m_err[k], e_done})
                    $display("FAIL rand_ctl i=%0d k=%0d got ren%0b wen%0b busy%0b hout%0b err%0b done%0b exp ren%0b wen%0b busy%0b hout%0b err%0b done%0b",
                             i, k, o_ren[k], o_wen[k], o_busy[k], o_hout[k], o_err[k], o_done[k],
                             e_busy && !m_w[k], e_busy && m_w[k], e_busy, m_halted[k], m_err[k], e_done);
                else pass_cnt++;
                if (e_busy) begin
                    total_cnt++;
                    if ({o_gid[k], o_addr[k]} !== {2'(m_owner[k]), m_addr[k]})
                        $display("FAIL rand_grant i=%0d k=%0d got gid%0d addr%0h exp gid%0d addr%0h",
                                 i, k, o_gid[k], o_addr[k], m_owner[k], m_addr[k]);
                    else pass_cnt++;
                end
            end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_fixed_prio();
        test_rr();
        test_halt();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
